mul_booth_iter: RTL and testbench

Parametrised iterative radix-4 Booth multiplier for the EXU. It retires K Booth digits per cycle, selectable at elaboration, and handles all four RV M-extension multiply flavours (mul/mulh/mulhsu/mulhu) through a sign pair and a high/low result select. It carries an opaque tag through to the output for writeback routing. It sits beside the ALU behind a valid/ready handshake and supports pipeline flush.

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_booth_iter_if.sv | 27 ++
 rtl/mul_booth_iter_booth_pp_sel.sv | 42 ++++
 rtl/mul_booth_iter.sv | 128 ++++++++++++
 tb/tb_mul_booth_iter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
// Sign-pair encodings, the Booth digit set and the compute-cycle count.
package mul_pkg;

  localparam logic [1:0] MUL_UU = 2'b00;
  localparam logic [1:0] MUL_SU = 2'b10;
  localparam logic [1:0] MUL_SS = 2'b11;

  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_dig_e;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_HOLD} mul_state_e;

  // Operands are extended by two bits so every flavour is a signed product.
  function automatic int calc_cycles(input int xlen, input int k);
    return ((xlen + 2) / 2 + k - 1) / k;
  endfunction

endpackage

// File: rtl/mul_booth_iter_if.sv
// Request/response bundle between the EXU issue logic and the multiplier.
interface mul_booth_iter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sign;
  logic             in_hi;
  logic [TAG_W-1:0] in_tag;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic             out_ready;
  logic             out_valid;
  logic [XLEN-1:0]  out_res;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_sign, in_hi, in_tag, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_tag
  );

  modport slave (
    input  in_valid, in_sign, in_hi, in_tag, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_tag
  );
endinterface

// File: rtl/mul_booth_iter_booth_pp_sel.sv
// Radix-4 Booth digit encoder and partial-product mux.
// The W+1-bit result leaves room for +/-2A without overflow.
module booth_pp_sel
  import mul_pkg::*;
#(
  parameter int W = 34
) (
  input  logic [2:0] triple_i,
  input  logic [W-1:0] a_i,
  output logic [W:0] pp_o
);

  booth_dig_e dig;
  logic [W:0] a_sx;
  logic [W:0] a2_sx;

  assign a_sx  = {a_i[W-1], a_i};
  assign a2_sx = {a_i, 1'b0};

  always_comb begin
    dig = ZERO;
    case (triple_i)
      3'b001, 3'b010: dig = P1;
      3'b011:         dig = P2;
      3'b100:         dig = M2;
      3'b101, 3'b110: dig = M1;
      default:        dig = ZERO;
    endcase
  end

  always_comb begin
    pp_o = '0;
    case (dig)
      P1:      pp_o = a_sx;
      P2:      pp_o = a2_sx;
      M1:      pp_o = -a_sx;
      M2:      pp_o = -a2_sx;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_iter.sv
// Iterative radix-4 Booth multiplier retiring K digits per cycle for
// mul/mulh/mulhsu/mulhu, with tag pass-through, backpressure and flush.
module mul_booth_iter
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int K     = 1,
  parameter int TAG_W = 4
) (
  input logic clock,
  input logic reset,
  input logic flush,
  mul_booth_iter_if.slave bus
);

  localparam int W  = XLEN + 2;
  localparam int D  = W / 2;
  localparam int C  = calc_cycles(XLEN, K);
  localparam int CW = $clog2(C + 1);

  mul_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             bm1_q;
  logic             hi_q;
  logic [TAG_W-1:0] tag_q;
  logic [2*W-1:0]   prod_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_res_q;
  logic [TAG_W-1:0] out_tag_q;

  logic [K:0][2*W-1:0] prod_c;
  logic [K:0][W-1:0]   b_c;
  logic [K:0]          bm1_c;
  logic [W-1:0]        a_ext;
  logic [W-1:0]        b_ext;
  logic                accept;
  logic                last;

  assign bus.in_ready = (state_q == ST_IDLE) | flush | ((state_q == ST_HOLD) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign a_ext        = {{2{bus.in_sign[1] & bus.in_a[XLEN-1]}}, bus.in_a};
  assign b_ext        = {{2{bus.in_sign[0] & bus.in_b[XLEN-1]}}, bus.in_b};
  assign last         = (cnt_q == CW'(C - 1));

  assign prod_c[0] = prod_q;
  assign b_c[0]    = b_q;
  assign bm1_c[0]  = bm1_q;

  // Stages past the last digit pass through, so a short final cycle is not over-shifted.
  for (genvar j = 0; j < K; j++) begin : g_stage
    logic [W:0]     pp;
    logic [W:0]     sum;
    logic [2*W+1:0] sh;
    logic           en;

    booth_pp_sel #(.W(W)) u_sel (
      .triple_i ({b_c[j][1:0], bm1_c[j]}),
      .a_i      (a_q),
      .pp_o     (pp)
    );

    assign sum = {prod_c[j][2*W-1], prod_c[j][2*W-1:W]} + pp;
    assign sh  = {sum[W], sum, prod_c[j][W-1:0]};
    assign en  = (int'(cnt_q) * K + j) < D;

    assign prod_c[j+1] = en ? sh[2*W+1:2] : prod_c[j];
    assign b_c[j+1]    = en ? {2'b00, b_c[j][W-1:2]} : b_c[j];
    assign bm1_c[j+1]  = en ? b_c[j][1] : bm1_c[j];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      bm1_q       <= 1'b0;
      hi_q        <= 1'b0;
      tag_q       <= '0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
    end else if (accept) begin
      a_q         <= a_ext;
      b_q         <= b_ext;
      bm1_q       <= 1'b0;
      hi_q        <= bus.in_hi;
      tag_q       <= bus.in_tag;
      prod_q      <= '0;
      cnt_q       <= '0;
      state_q     <= ST_BUSY;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BUSY: begin
          prod_q <= prod_c[K];
          b_q    <= b_c[K];
          bm1_q  <= bm1_c[K];
          cnt_q  <= cnt_q + CW'(1);
          if (last) begin
            state_q     <= ST_HOLD;
            out_valid_q <= 1'b1;
            out_res_q   <= hi_q ? prod_c[K][2*XLEN-1:XLEN] : prod_c[K][XLEN-1:0];
            out_tag_q   <= tag_q;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q & ~flush;
  assign bus.out_res   = out_res_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_mul_booth_iter.sv
// Scoreboard bench for mul_booth_iter: K=1 directed/flush/reset/random traffic,
// plus K=2 and K=4 instances checked on the same corner products.
module tb_mul_booth_iter;
  import mul_pkg::*;

  localparam int C1 = 17;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic reset_k = 1'b1;
  logic flush   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];

  mul_booth_iter_if #(.XLEN(32), .TAG_W(4)) bif ();

  mul_booth_iter #(.XLEN(32), .K(1), .TAG_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] s, input logic hi,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae, be, p;
    ae = s[1] ? {{32{a[31]}}, a} : {32'd0, a};
    be = s[0] ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ae * be;
    return hi ? p[63:32] : p[31:0];
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset && bif.out_valid && bif.out_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res", 64'(bif.out_res), 64'(e.res));
        chk("tag", 64'(bif.out_tag), 64'(e.tag));
      end
    end
  end

  task automatic send(input logic [1:0] s, input logic hi, input logic [3:0] tag,
                      input logic [31:0] a, input logic [31:0] b, output int waited);
    bit ok;
    ok = 0;
    waited = 0;
    bif.in_valid = 1'b1;
    bif.in_sign  = s;
    bif.in_hi    = hi;
    bif.in_tag   = tag;
    bif.in_a     = a;
    bif.in_b     = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bif.in_ready) begin
        sb.push_back('{ref_mul(s, hi, a, b), tag});
        ok = 1;
        break;
      end
      waited++;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    bif.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(input int lat_exp, input string tag);
    int n;
    n = 0;
    while (!bif.out_valid && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk(tag, 64'(n), 64'(lat_exp));
  endtask

  task automatic run_op(input logic [1:0] s, input logic hi, input logic [3:0] tag,
                        input logic [31:0] a, input logic [31:0] b);
    int w;
    send(s, hi, tag, a, b, w);
    wait_valid(C1, "lat");
    @(posedge clock); #1;
  endtask

  initial begin
    int w;
    logic [31:0] r0;
    bif.in_valid  = 1'b0;
    bif.in_sign   = 2'b00;
    bif.in_hi     = 1'b0;
    bif.in_tag    = '0;
    bif.in_a      = '0;
    bif.in_b      = '0;
    bif.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ov",  64'(bif.out_valid), 64'd0);
    chk("rst_ir",  64'(bif.in_ready), 64'd1);
    chk("rst_res", 64'(bif.out_res), 64'd0);
    chk("rst_tag", 64'(bif.out_tag), 64'd0);
    reset   = 1'b0;
    reset_k = 1'b0;

    run_op(MUL_UU, 1'b1, 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(MUL_UU, 1'b0, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(MUL_SS, 1'b1, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(MUL_SS, 1'b0, 4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(MUL_SS, 1'b1, 4'd5, 32'h80000000, 32'h80000000);
    run_op(MUL_SS, 1'b0, 4'd6, 32'h80000000, 32'h80000000);
    run_op(MUL_SU, 1'b1, 4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("dir_hi_uu", 64'(ref_mul(MUL_UU, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'h00000000FFFFFFFE);

    // Backpressure in HOLD, then back-to-back accept on release
    bif.out_ready = 1'b0;
    send(MUL_SS, 1'b0, 4'd5, 32'h00001234, 32'hFFFF5678, w);
    wait_valid(C1, "bp_lat");
    r0 = ref_mul(MUL_SS, 1'b0, 32'h00001234, 32'hFFFF5678);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("bp_res", 64'(bif.out_res), 64'(r0));
      chk("bp_tag", 64'(bif.out_tag), 64'd5);
      chk("bp_ir",  64'(bif.in_ready), 64'd0);
      chk("bp_ov",  64'(bif.out_valid), 64'd1);
    end
    bif.out_ready = 1'b1;
    send(MUL_UU, 1'b1, 4'd6, 32'hDEADBEEF, 32'hCAFEF00D, w);
    chk("b2b_wait", 64'(w), 64'd0);
    wait_valid(C1, "b2b_lat");
    @(posedge clock); #1;

    // Flush 5 cycles into BUSY with a new request in the same cycle
    send(MUL_UU, 1'b0, 4'd1, 32'h11111111, 32'h00000003, w);
    repeat (5) begin @(posedge clock); #1; end
    flush        = 1'b1;
    bif.in_valid = 1'b1;
    bif.in_sign  = MUL_SS;
    bif.in_hi    = 1'b0;
    bif.in_tag   = 4'd3;
    bif.in_a     = 32'h00000007;
    bif.in_b     = 32'hFFFFFFF7;
    @(negedge clock);
    chk("fl_ir", 64'(bif.in_ready), 64'd1);
    sb.delete();
    sb.push_back('{ref_mul(MUL_SS, 1'b0, 32'h00000007, 32'hFFFFFFF7), 4'd3});
    @(posedge clock); #1;
    flush        = 1'b0;
    bif.in_valid = 1'b0;
    wait_valid(C1, "fl_lat");
    chk("fl_tag", 64'(bif.out_tag), 64'd3);
    @(posedge clock); #1;

    // Flush while holding a result
    bif.out_ready = 1'b0;
    send(MUL_UU, 1'b1, 4'd9, 32'h0000FFFF, 32'h0000FFFF, w);
    wait_valid(C1, "flh_lat");
    flush = 1'b1;
    @(negedge clock);
    chk("flh_ov", 64'(bif.out_valid), 64'd0);
    chk("flh_ir", 64'(bif.in_ready), 64'd1);
    sb.delete();
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flh_idle", 64'(bif.out_valid), 64'd0);
    bif.out_ready = 1'b1;

    // Reset in BUSY
    send(MUL_SS, 1'b1, 4'd2, 32'h12345678, 32'h87654321, w);
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rb_ov", 64'(bif.out_valid), 64'd0);
    chk("rb_ir", 64'(bif.in_ready), 64'd1);
    reset = 1'b0;
    sb.delete();

    // Reset in HOLD
    bif.out_ready = 1'b0;
    send(MUL_UU, 1'b0, 4'd4, 32'h00000100, 32'h00000100, w);
    wait_valid(C1, "rh_lat");
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rh_ov", 64'(bif.out_valid), 64'd0);
    chk("rh_ir", 64'(bif.in_ready), 64'd1);
    reset = 1'b0;
    sb.delete();
    bif.out_ready = 1'b1;

    // Random regression, all four sign pairs, back-to-back issue
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 300; n++) begin
        logic [31:0] ra, rb;
        ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
        rb = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
        send(2'(s), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, rb, w);
      end
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clock);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);

    for (int i = 0; i < 5000 && !(g_k[0].done && g_k[1].done); i++) @(posedge clock);
    chk("k_done", 64'(g_k[0].done && g_k[1].done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  for (genvar g = 0; g < 2; g++) begin : g_k
    localparam int KK  = (g == 0) ? 2 : 4;
    localparam int LAT = (g == 0) ? 9 : 5;
    bit done = 1'b0;

    mul_booth_iter_if #(.XLEN(32), .TAG_W(4)) kif ();

    mul_booth_iter #(.XLEN(32), .K(KK), .TAG_W(4)) u_dut (
      .clock (clock),
      .reset (reset_k),
      .flush (1'b0),
      .bus   (kif)
    );

    initial begin
      logic [1:0]  vs[4];
      logic        vh[4];
      logic [31:0] va[4];
      logic [31:0] vb[4];
      vs = '{MUL_SU, MUL_UU, MUL_SS, MUL_UU};
      vh = '{1'b1, 1'b1, 1'b1, 1'b0};
      va = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
      vb = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h9ABCDEF0};
      kif.in_valid  = 1'b0;
      kif.in_sign   = 2'b00;
      kif.in_hi     = 1'b0;
      kif.in_tag    = '0;
      kif.in_a      = '0;
      kif.in_b      = '0;
      kif.out_ready = 1'b1;
      wait (!reset_k);
      @(posedge clock); #1;
      for (int v = 0; v < 4; v++) begin
        int n;
        kif.in_valid = 1'b1;
        kif.in_sign  = vs[v];
        kif.in_hi    = vh[v];
        kif.in_tag   = 4'(v + 8);
        kif.in_a     = va[v];
        kif.in_b     = vb[v];
        @(negedge clock);
        chk($sformatf("k%0d_ir", KK), 64'(kif.in_ready), 64'd1);
        @(posedge clock); #1;
        kif.in_valid = 1'b0;
        n = 0;
        while (!kif.out_valid && n < 50) begin
          @(posedge clock); #1;
          n++;
        end
        chk($sformatf("k%0d_lat", KK), 64'(n), 64'(LAT));
        chk($sformatf("k%0d_res", KK), 64'(kif.out_res), 64'(ref_mul(vs[v], vh[v], va[v], vb[v])));
        chk($sformatf("k%0d_tag", KK), 64'(kif.out_tag), 64'(v + 8));
        @(posedge clock); #1;
      end
      done = 1'b1;
    end
  end

endmodule
